// File: rtl/riscv_pkg.sv
// Shared RV32I execute-stage definitions: ALU operation encodings and
// branch funct3 selectors used by the ALU, comparator and their consumers.
package riscv_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_op_e;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/alu.sv
// Combinational RV32I integer ALU; encodings 11-15 produce zero so that
// undefined operations never leak stale operand data downstream.
module alu
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] in1,
    input  logic [XLEN-1:0] in2,
    input  logic [3:0]      alu_op,
    output logic [XLEN-1:0] result
);

    localparam int SHW = $clog2(XLEN);

    alu_op_e          op;
    logic [SHW-1:0]   shamt;
    logic             lt_s;
    logic             lt_u;

    assign op    = alu_op_e'(alu_op);
    assign shamt = in2[SHW-1:0];
    assign lt_s  = $signed(in1) < $signed(in2);
    assign lt_u  = in1 < in2;

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:    result = in1 + in2;
            ALU_SUB:    result = in1 - in2;
            ALU_SLL:    result = in1 << shamt;
            ALU_SLT:    result = {{(XLEN-1){1'b0}}, lt_s};
            ALU_SLTU:   result = {{(XLEN-1){1'b0}}, lt_u};
            ALU_XOR:    result = in1 ^ in2;
            ALU_SRL:    result = in1 >> shamt;
            ALU_SRA:    result = $unsigned($signed(in1) >>> shamt);
            ALU_OR:     result = in1 | in2;
            ALU_AND:    result = in1 & in2;
            ALU_PASS_B: result = in2;
            default:    result = '0;
        endcase
    end

endmodule

// File: rtl/compare.sv
// Combinational branch comparator; the two reserved funct3 codes resolve
// to not-taken so a malformed branch can never redirect the PC.
module compare
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] in1,
    input  logic [XLEN-1:0] in2,
    input  logic [2:0]      funct3,
    output logic            cond
);

    logic eq;
    logic lt_s;
    logic lt_u;

    assign eq   = in1 == in2;
    assign lt_s = $signed(in1) < $signed(in2);
    assign lt_u = in1 < in2;

    always_comb begin
        cond = 1'b0;
        case (funct3)
            F3_BEQ:  cond = eq;
            F3_BNE:  cond = ~eq;
            F3_BLT:  cond = lt_s;
            F3_BGE:  cond = ~lt_s;
            F3_BLTU: cond = lt_u;
            F3_BGEU: cond = ~lt_u;
            default: cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_alu_cmp.sv
// Execute-stage core: ALU result and branch condition captured in a single
// pipeline register; data registers hold while no instruction is presented.
module ex_alu_cmp
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [XLEN-1:0] alu_in1,
    input  logic [XLEN-1:0] alu_in2,
    input  logic [3:0]      alu_op,
    input  logic [XLEN-1:0] cmp_in1,
    input  logic [XLEN-1:0] cmp_in2,
    input  logic [2:0]      funct3,
    output logic            out_valid,
    output logic [XLEN-1:0] alu_result,
    output logic            cond
);

    logic [XLEN-1:0] alu_res;
    logic            cmp_cond;

    logic            out_valid_d,  out_valid_q;
    logic [XLEN-1:0] alu_result_d, alu_result_q;
    logic            cond_d,       cond_q;

    alu #(.XLEN(XLEN)) u_alu (
        .in1    (alu_in1),
        .in2    (alu_in2),
        .alu_op (alu_op),
        .result (alu_res)
    );

    compare #(.XLEN(XLEN)) u_compare (
        .in1    (cmp_in1),
        .in2    (cmp_in2),
        .funct3 (funct3),
        .cond   (cmp_cond)
    );

    // Holding data on bubbles lets the memory stage reuse the last address.
    always_comb begin
        out_valid_d  = in_valid;
        alu_result_d = alu_result_q;
        cond_d       = cond_q;
        if (in_valid) begin
            alu_result_d = alu_res;
            cond_d       = cmp_cond;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            alu_result_q <= '0;
            cond_q       <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            alu_result_q <= alu_result_d;
            cond_q       <= cond_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign alu_result = alu_result_q;
    assign cond       = cond_q;

endmodule

// File: tb/tb_ex_alu_cmp.sv
// Self-checking bench for ex_alu_cmp: vector table through a scoreboard
// queue, plus hand-written reset and hold sequences.
module tb_ex_alu_cmp;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] alu_in1;
    logic [31:0] alu_in2;
    logic [3:0]  alu_op;
    logic [31:0] cmp_in1;
    logic [31:0] cmp_in2;
    logic [2:0]  funct3;
    logic        out_valid;
    logic [31:0] alu_result;
    logic        cond;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        logic        vin;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c1;
        logic [31:0] c2;
        logic [2:0]  f3;
        logic [31:0] er;
        logic        ec;
        logic        ev;
    } vec_t;

    vec_t tbl[16];
    vec_t sbq[$];

    ex_alu_cmp #(.XLEN(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .alu_in1    (alu_in1),
        .alu_in2    (alu_in2),
        .alu_op     (alu_op),
        .cmp_in1    (cmp_in1),
        .cmp_in2    (cmp_in2),
        .funct3     (funct3),
        .out_valid  (out_valid),
        .alu_result (alu_result),
        .cond       (cond)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".alu_result"}, alu_result, 32'h0);
        check({tag, ".cond"}, {31'b0, cond}, 32'h0);
        check({tag, ".out_valid"}, {31'b0, out_valid}, 32'h0);
    endtask

    // Drive one cycle of stimulus on the falling edge, score after the rising edge.
    task automatic drive(input vec_t v, input string tag);
        vec_t e;
        @(negedge clk);
        in_valid = v.vin;
        alu_op   = v.op;
        alu_in1  = v.a;
        alu_in2  = v.b;
        cmp_in1  = v.c1;
        cmp_in2  = v.c2;
        funct3   = v.f3;
        sbq.push_back(v);
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        $display("%s: v=%0b op=%0d a=%08h b=%08h c1=%08h c2=%08h f3=%03b -> res=%08h cond=%0b ov=%0b",
                 tag, e.vin, e.op, e.a, e.b, e.c1, e.c2, e.f3, alu_result, cond, out_valid);
        check({tag, ".alu_result"}, alu_result, e.er);
        check({tag, ".cond"}, {31'b0, cond}, {31'b0, e.ec});
        check({tag, ".out_valid"}, {31'b0, out_valid}, {31'b0, e.ev});
    endtask

    initial begin
        //          vin  op     a             b             c1            c2            f3      er            ec    ev
        tbl[0]  = '{1'b1, 4'd0,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h00000000, 3'b000, 32'h00000000, 1'b1, 1'b1};
        tbl[1]  = '{1'b1, 4'd1,  32'h00000000, 32'h00000001, 32'h00000000, 32'h00000001, 3'b000, 32'hFFFFFFFF, 1'b0, 1'b1};
        tbl[2]  = '{1'b1, 4'd7,  32'h80000000, 32'h00000024, 32'h00000005, 32'h00000005, 3'b001, 32'hF8000000, 1'b0, 1'b1};
        tbl[3]  = '{1'b1, 4'd6,  32'h80000000, 32'h00000024, 32'h00000001, 32'h00000002, 3'b001, 32'h08000000, 1'b1, 1'b1};
        tbl[4]  = '{1'b1, 4'd2,  32'h00000001, 32'h00000024, 32'hFFFFFFFE, 32'h00000001, 3'b100, 32'h00000010, 1'b1, 1'b1};
        tbl[5]  = '{1'b1, 4'd3,  32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 32'h00000001, 3'b101, 32'h00000001, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 4'd4,  32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 32'h00000001, 3'b110, 32'h00000000, 1'b0, 1'b1};
        tbl[7]  = '{1'b1, 4'd10, 32'hDEADBEEF, 32'h12345000, 32'hFFFFFFFE, 32'h00000001, 3'b111, 32'h12345000, 1'b1, 1'b1};
        tbl[8]  = '{1'b1, 4'd15, 32'h00000001, 32'h00000002, 32'hFFFFFFFE, 32'h00000001, 3'b001, 32'h00000000, 1'b1, 1'b1};
        tbl[9]  = '{1'b1, 4'd0,  32'h00000003, 32'h00000004, 32'hFFFFFFFE, 32'h00000001, 3'b000, 32'h00000007, 1'b0, 1'b1};
        tbl[10] = '{1'b1, 4'd5,  32'hF0F0F0F0, 32'hFF00FF00, 32'hFFFFFFFE, 32'h00000001, 3'b010, 32'h0FF00FF0, 1'b0, 1'b1};
        tbl[11] = '{1'b1, 4'd8,  32'hF0F0F0F0, 32'h0F0F0000, 32'h00000007, 32'h00000007, 3'b011, 32'hFFFFF0F0, 1'b0, 1'b1};
        tbl[12] = '{1'b1, 4'd9,  32'hF0F0F0F0, 32'hFF00FF00, 32'hFFFFFFFE, 32'h00000001, 3'b111, 32'hF000F000, 1'b1, 1'b1};
        tbl[13] = '{1'b1, 4'd11, 32'h12345678, 32'h9ABCDEF0, 32'h00000001, 32'hFFFFFFFE, 3'b110, 32'h00000000, 1'b1, 1'b1};
        tbl[14] = '{1'b1, 4'd3,  32'h00000001, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 3'b101, 32'h00000000, 1'b1, 1'b1};
        tbl[15] = '{1'b1, 4'd1,  32'h00000005, 32'h00000007, 32'h00000005, 32'h00000007, 3'b100, 32'hFFFFFFFE, 1'b1, 1'b1};

        in_valid = 1'b0;
        alu_op   = 4'd0;
        alu_in1  = 32'h0;
        alu_in2  = 32'h0;
        cmp_in1  = 32'h0;
        cmp_in2  = 32'h0;
        funct3   = 3'b000;
        rst_n    = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check_zero("reset_init");

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i], $sformatf("vec%0d", i));
        end

        // Outputs now 0xFFFFFFFE / cond=1 / valid=1; reset must clear them mid-cycle.
        #2 rst_n = 1'b0;
        #1;
        check_zero("reset_async");

        @(negedge clk);
        in_valid = 1'b1;
        alu_op   = 4'd0;
        alu_in1  = 32'h00000011;
        alu_in2  = 32'h00000022;
        cmp_in1  = 32'h0;
        cmp_in2  = 32'h0;
        funct3   = 3'b000;
        @(posedge clk);
        #1;
        check_zero("reset_held_edge");

        rst_n = 1'b1;
        drive('{1'b1, 4'd0, 32'h00000050, 32'h00000005, 32'h00000003, 32'h00000003, 3'b000,
                32'h00000055, 1'b1, 1'b1}, "hold_load");
        drive('{1'b0, 4'd0, 32'h00000001, 32'h00000001, 32'h00000003, 32'h00000004, 3'b000,
                32'h00000055, 1'b1, 1'b0}, "hold_bubble");
        drive('{1'b0, 4'd9, 32'hFFFFFFFF, 32'h0000FFFF, 32'h00000000, 32'h00000009, 3'b001,
                32'h00000055, 1'b1, 1'b0}, "hold_bubble2");
        drive('{1'b1, 4'd10, 32'h00000000, 32'hABCDE000, 32'h00000003, 32'h00000004, 3'b000,
                32'hABCDE000, 1'b0, 1'b1}, "hold_release");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
